// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encodings,
// opcodes, datapath mux codes and the bundled control-output struct.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11,
        TRAP      = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       zero_ext;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // State entered after DECODE for a given opcode; unknown opcodes trap.
    function automatic state_e decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:     return MEM_ADDR;
            OP_RTYPE:         return R_EXEC;
            OP_BEQ:           return BRANCH;
            OP_J:             return JUMP;
            OP_ADDI, OP_ANDI: return I_EXEC;
            default:          return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Control bus between the multi-cycle controller and the MIPS datapath.
// master = controller side, slave = datapath side.
interface multi_cycle_control_if #(parameter int CNT_W = 32) ();

    logic [5:0]       OpCode;
    logic             MemReady;
    logic             Stall;
    logic             Zero;

    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic             ALUSrcA;
    logic             RegWrite;
    logic             RegDst;
    logic             ZeroExt;
    logic [1:0]       PCSource;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [3:0]       State;
    logic             InstrDone;
    logic             Illegal;
    logic [CNT_W-1:0] RetiredCount;

    modport master (
        input  OpCode, MemReady, Stall, Zero,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, ZeroExt, PCSource, ALUSrcB, ALUOp,
               State, InstrDone, Illegal, RetiredCount
    );

    modport slave (
        output OpCode, MemReady, Stall, Zero,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, ZeroExt, PCSource, ALUSrcB, ALUOp,
               State, InstrDone, Illegal, RetiredCount
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Purely combinational decode of (state, opcode, handshake) into the
// datapath control lines. Moore outputs except the FETCH/MEM_WRITE handshake terms.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    input  logic       stall,
    output ctrl_t      ctrl
);

    // Per-state control decode.
    always_comb begin
        // NOTE: every field defaults to 0 first, so a state that omits a signal cannot infer a latch.
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = ~stall;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready & ~stall;
                ctrl.pc_write  = mem_ready & ~stall;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                if (op_code == OP_ANDI) begin
                    ctrl.alu_op   = ALUOP_AND;
                    ctrl.zero_ext = 1'b1;
                end else begin
                    ctrl.alu_op   = ALUOP_ADD;
                end
            end
            I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS controller: state register, next-state sequencing,
// retired-instruction counter; output decode lives in mc_ctrl_decode.
module multi_cycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    multi_cycle_control_if.master bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_count_q, retired_count_d;
    ctrl_t            ctrl, ctrl_out;

    // The branch decision (PCWriteCond & Zero) is resolved in the datapath.
    logic unused_zero;
    assign unused_zero = bus.Zero;

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .op_code   (bus.OpCode),
        .mem_ready (bus.MemReady),
        .stall     (bus.Stall),
        .ctrl      (ctrl)
    );

    // Next-state sequencing and retired-instruction count.
    always_comb begin
        state_d         = state_q;
        retired_count_d = retired_count_q + CNT_W'(ctrl.instr_done);
        case (state_q)
            FETCH:     if (!bus.Stall && bus.MemReady) state_d = DECODE;
            DECODE:    state_d = decode_target(bus.OpCode);
            MEM_ADDR:  state_d = (bus.OpCode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (bus.MemReady) state_d = MEM_WB;
            MEM_WRITE: if (bus.MemReady) state_d = FETCH;
            R_EXEC:    state_d = R_WB;
            I_EXEC:    state_d = I_WB;
            MEM_WB, R_WB, BRANCH, JUMP, I_WB: state_d = FETCH;
            TRAP:      state_d = TRAP;
            default:   state_d = TRAP;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q         <= FETCH;
            retired_count_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q         <= state_d;
            retired_count_q <= retired_count_d;
        end
    end

    // Controls are held at 0 for as long as reset is asserted.
    assign ctrl_out = Rst_n ? ctrl : '0;

    assign bus.PCWrite      = ctrl_out.pc_write;
    assign bus.PCWriteCond  = ctrl_out.pc_write_cond;
    assign bus.IorD         = ctrl_out.i_or_d;
    assign bus.MemRead      = ctrl_out.mem_read;
    assign bus.MemWrite     = ctrl_out.mem_write;
    assign bus.MemtoReg     = ctrl_out.mem_to_reg;
    assign bus.IRWrite      = ctrl_out.ir_write;
    assign bus.ALUSrcA      = ctrl_out.alu_src_a;
    assign bus.RegWrite     = ctrl_out.reg_write;
    assign bus.RegDst       = ctrl_out.reg_dst;
    assign bus.ZeroExt      = ctrl_out.zero_ext;
    assign bus.PCSource     = ctrl_out.pc_source;
    assign bus.ALUSrcB      = ctrl_out.alu_src_b;
    assign bus.ALUOp        = ctrl_out.alu_op;
    assign bus.InstrDone    = ctrl_out.instr_done;
    assign bus.Illegal      = ctrl_out.illegal;
    assign bus.State        = state_q;
    assign bus.RetiredCount = retired_count_q;

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore/Mealy FSM that sequences the multi-cycle MIPS datapath (shared memory, IR, ALUOut, PC) over the opcodes 000000, 000010, 000100, 100011, 101011, 001000 and 001100.
- Sits between the instruction register opcode field and the datapath mux/enable lines.
- Waits on a memory ready handshake, counts retired instructions and traps on illegal opcodes.

Parameters:
- CNT_W, 32, width of the RetiredCount counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- OpCode  in  6  IR[31:26]; IR is written only in FETCH, so OpCode is stable after FETCH.
- MemReady  in  1  memory has completed the current read/write this cycle.
- Stall  in  1  hold in FETCH; no new fetch is started.
- Zero  in  1  ALU zero flag (BEQ).
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, ZeroExt  out  1 each  datapath controls.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = imm, 11 = imm<<2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct, 11 = and.
- State  out  4  current state (debug).
- InstrDone  out  1  one-cycle pulse on the final cycle of each instruction.
- Illegal  out  1  sticky; high while in TRAP.
- RetiredCount  out  CNT_W  instructions retired.

Behaviour:
- Reset: async on Rst_n=0 -> State=FETCH, RetiredCount=0. While Rst_n=0 all control outputs are forced to 0. After release, outputs follow the state decode below. Reset mid-instruction aborts it; there is no partial-write protection.
- Default for every output is 0 unless listed for a state.
- FETCH:
  - Outputs: MemRead=1, ALUSrcB=01. IRWrite = PCWrite = MemReady & ~Stall.
  - Stall=1 -> MemRead=0 and hold in FETCH.
  - Stall=0 & MemReady=1 -> go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: ALUSrcB=11.
  - Next state by OpCode: 100011/101011 -> MEM_ADDR; 000000 -> R_EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000/001100 -> I_EXEC; any other -> TRAP.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Go to MEM_WB when MemReady, else stay.
- MEM_WB: RegWrite=1, MemtoReg=1, InstrDone=1 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. When MemReady: InstrDone=1 -> FETCH. Otherwise stay, with MemWrite held.
- R_EXEC: ALUSrcA=1, ALUOp=10 -> R_WB.
- R_WB: RegWrite=1, RegDst=1, InstrDone=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1 -> FETCH. PC update = PCWriteCond & Zero is done in the datapath.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1 -> FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10.
  - addi: ALUOp=00, ZeroExt=0.
  - andi: ALUOp=11, ZeroExt=1.
  - Next -> I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1 -> FETCH.
- TRAP: all controls 0, Illegal=1. Only reset exits TRAP.
- Latency with MemReady tied to 1, in cycles including FETCH: R 4, lw 5, sw 4, beq 3, j 3, addi/andi 4. Each cycle of MemReady=0 in a memory state adds 1 cycle.
- RetiredCount increments by 1 on each cycle with InstrDone=1 and wraps modulo 2^CNT_W.
- Stall is ignored outside FETCH, so an in-flight instruction always completes.
- Simultaneous Stall=1 and MemReady=1 in FETCH: Stall wins; there are no IRWrite/PCWrite side effects.

Decomposition:
- Shared package mc_ctrl_pkg contains:
  - state encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=15;
  - opcode constants;
  - ALUOp, ALUSrcB and PCSource code constants.
- One natural sub-module, mc_ctrl_decode: purely combinational state+OpCode -> control-output decode. The top module holds the state register, next-state logic and counter.

Test Plan:
- Reset with Rst_n=0 mid-MEM_READ -> State=0, all controls 0, RetiredCount=0 immediately (async); after release, FETCH outputs MemRead=1, ALUSrcB=01.
- MemReady=1, OpCode=100011 -> states 0,1,2,3,4. In state 4: RegWrite=1, MemtoReg=1, InstrDone=1. RetiredCount goes 0->1.
- OpCode=101011 with MemReady low for 3 cycles in MEM_WRITE -> MemWrite=1 held 4 cycles, InstrDone only on the MemReady cycle, total 7 cycles.
- Sequence 000000, 000100, 000010, 001100 with MemReady=1 -> 4+3+3+4 = 14 cycles, RetiredCount=4. andi I_EXEC shows ALUOp=11, ZeroExt=1. BRANCH shows ALUOp=01, PCWriteCond=1.
- Stall=1 for 5 cycles in FETCH with MemReady=1 -> IRWrite=PCWrite=MemRead=0, State stays 0. Stall asserted during R_EXEC -> instruction still completes.
- OpCode=111111 -> DECODE then TRAP (15), Illegal=1, all controls 0 for 20 cycles, no InstrDone. Rst_n pulse -> FETCH, Illegal=0.
